// File: rtl/rej_sampler_stream.sv
// Streaming rejection sampler for Dilithium polynomial generation.
// Turns a SHAKE byte stream into accepted uniform (mod Q) or eta coefficients.
module rej_sampler_stream #(
   parameter int          N       = 256,
   parameter int          CNT_W   = 9,
   parameter int          COEFF_W = 32,
   parameter int unsigned Q       = 8380417
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [CNT_W-1:0]   len,
   input  logic [7:0]         in_byte,
   input  logic               in_valid,
   input  logic               in_last,
   output logic               in_ready,
   output logic [COEFF_W-1:0] coeff_out,
   output logic [CNT_W-1:0]   coeff_idx,
   output logic               coeff_valid,
   input  logic               coeff_ready,
   output logic [CNT_W-1:0]   ctr,
   output logic               busy,
   output logic               done,
   output logic               exhausted
);

   typedef enum logic [2:0] {IDLE, COLLECT, EVAL, EMIT, DONE} state_t;

   state_t             state, state_n;
   logic [1:0]         mode_r;
   logic [CNT_W-1:0]   len_eff, len_c, ctr_n;
   logic [23:0]        t, cand;
   logic [1:0]         bcnt;
   logic               nib_sel, last_seen;

   logic               is_eta, hs_in, hs_out, last_coeff, more_nib, accept;
   logic [3:0]         nib, nmod, eta_v;
   logic [COEFF_W-1:0] value;

   always_comb begin
      is_eta     = (mode_r == 2'd1) || (mode_r == 2'd2);
      hs_in      = in_valid && in_ready;
      hs_out     = coeff_valid && coeff_ready;
      last_coeff = (ctr + CNT_W'(1)) == len_eff;
      more_nib   = is_eta && !nib_sel;
      len_c      = (len > CNT_W'(N)) ? CNT_W'(N) : len;

      cand  = t & 24'h7F_FFFF;
      nib   = nib_sel ? t[7:4] : t[3:0];
      nmod  = nib % 4'd5;
      // 4-bit wraparound subtraction yields the two's-complement eta value
      if (mode_r == 2'd1) begin
         accept = nib < 4'd15;
         eta_v  = 4'd2 - nmod;
      end else if (mode_r == 2'd2) begin
         accept = nib < 4'd9;
         eta_v  = 4'd4 - nib;
      end else begin
         accept = cand < 24'(Q);
         eta_v  = '0;
      end
      value = is_eta ? {{(COEFF_W-4){eta_v[3]}}, eta_v}
                     : {{(COEFF_W-24){1'b0}}, cand};

      ctr_n = ctr;
      if (state == IDLE && start) ctr_n = '0;
      else if (hs_out)            ctr_n = ctr + CNT_W'(1);

      state_n = state;
      case (state)
         IDLE:    if (start) state_n = (len_c == '0) ? DONE : COLLECT;
         COLLECT: if (hs_in) begin
                     if (is_eta || bcnt == 2'd2) state_n = EVAL;
                     else if (in_last)           state_n = DONE;
                  end
         EVAL:    if (accept)        state_n = EMIT;
                  else if (more_nib) state_n = EVAL;
                  else if (last_seen) state_n = DONE;
                  else               state_n = COLLECT;
         EMIT:    if (hs_out) begin
                     if (last_coeff)     state_n = DONE;
                     else if (more_nib)  state_n = EVAL;
                     else if (last_seen) state_n = DONE;
                     else                state_n = COLLECT;
                  end
         DONE:    if (!start) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         mode_r      <= '0;
         len_eff     <= '0;
         t           <= '0;
         bcnt        <= '0;
         nib_sel     <= 1'b0;
         last_seen   <= 1'b0;
         in_ready    <= 1'b0;
         coeff_valid <= 1'b0;
         coeff_out   <= '0;
         coeff_idx   <= '0;
         ctr         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         exhausted   <= 1'b0;
      end else begin
         state       <= state_n;
         ctr         <= ctr_n;
         in_ready    <= (state_n == COLLECT);
         coeff_valid <= (state_n == EMIT);
         busy        <= (state_n == COLLECT) || (state_n == EVAL) || (state_n == EMIT);
         done        <= (state_n == DONE);

         // Only an emit-driven finish can have reached len; every other way into DONE is short
         if (state != DONE && state_n == DONE)
            exhausted <= (state != IDLE) && (ctr_n < len_eff);
         else if (state_n == IDLE)
            exhausted <= 1'b0;

         case (state)
            IDLE: if (start) begin
               mode_r    <= mode;
               len_eff   <= len_c;
               t         <= '0;
               bcnt      <= '0;
               nib_sel   <= 1'b0;
               last_seen <= 1'b0;
            end
            COLLECT: if (hs_in) begin
               if (is_eta) begin
                  t[7:0]    <= in_byte;
                  nib_sel   <= 1'b0;
                  last_seen <= in_last;
               end else begin
                  t[{bcnt, 3'b000} +: 8] <= in_byte;
                  if (bcnt == 2'd2) begin
                     bcnt      <= '0;
                     last_seen <= in_last;
                  end else begin
                     bcnt <= bcnt + 2'd1;
                  end
               end
            end
            EVAL: begin
               if (accept) begin
                  coeff_out <= value;
                  coeff_idx <= ctr;
               end else if (more_nib) begin
                  nib_sel <= 1'b1;
               end
            end
            EMIT: if (hs_out && more_nib) nib_sel <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rej_sampler_stream.sv
// Directed bench for rej_sampler_stream: expected coefficients are queued
// before the bytes are sent and compared as the DUT hands them over.
module tb_rej_sampler_stream;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  mode;
   logic [8:0]  len;
   logic [7:0]  in_byte;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [31:0] coeff_out;
   logic [8:0]  coeff_idx;
   logic        coeff_valid;
   logic        coeff_ready;
   logic [8:0]  ctr;
   logic        busy;
   logic        done;
   logic        exhausted;

   typedef struct packed {
      logic [31:0] v;
      logic [8:0]  i;
   } exp_t;

   exp_t sb[$];
   exp_t got;
   int   checks   = 0;
   int   failures = 0;

   rej_sampler_stream #(.N(256), .CNT_W(9), .COEFF_W(32), .Q(8380417)) dut (
      .clock(clock), .reset(reset), .start(start), .mode(mode), .len(len),
      .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .coeff_out(coeff_out), .coeff_idx(coeff_idx), .coeff_valid(coeff_valid),
      .coeff_ready(coeff_ready), .ctr(ctr), .busy(busy), .done(done), .exhausted(exhausted)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [31:0] v, input logic [8:0] i);
      exp_t e;
      e.v = v;
      e.i = i;
      sb.push_back(e);
   endtask

   task automatic send(input logic [7:0] b, input logic last);
      bit taken = 0;
      in_byte  = b;
      in_last  = last;
      in_valid = 1'b1;
      for (int n = 0; n < 200 && !taken; n++) begin
         @(negedge clock);
         if (in_ready) taken = 1;
      end
      check("byte_accepted", {63'd0, taken}, 64'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done();
      for (int n = 0; n < 200 && !done; n++) @(negedge clock);
      check("done_reached", {63'd0, done}, 64'd1);
   endtask

   task automatic begin_run(input logic [1:0] m, input logic [8:0] l);
      mode  = m;
      len   = l;
      start = 1'b1;
   endtask

   task automatic end_run();
      start = 1'b0;
      tick();
      @(negedge clock);
      check("done_drops", {63'd0, done}, 64'd0);
      check("sb_drained", 64'(sb.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
      check({tag, "_coeff_valid"}, {63'd0, coeff_valid}, 64'd0);
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
      check({tag, "_done"}, {63'd0, done}, 64'd0);
      check({tag, "_exhausted"}, {63'd0, exhausted}, 64'd0);
      check({tag, "_ctr"}, 64'(ctr), 64'd0);
      check({tag, "_coeff_out"}, 64'(coeff_out), 64'd0);
      check({tag, "_coeff_idx"}, 64'(coeff_idx), 64'd0);
   endtask

   // Scoreboard side: a handshake seen here completes on the next rising edge
   always @(negedge clock) begin
      if (!reset && coeff_valid && coeff_ready) begin
         check("sb_has_entry", {63'd0, sb.size() != 0}, 64'd1);
         if (sb.size() != 0) begin
            got = sb.pop_front();
            check("coeff_value", 64'(coeff_out), 64'(got.v));
            check("coeff_index", 64'(coeff_idx), 64'(got.i));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      mode        = 2'd0;
      len         = '0;
      in_byte     = '0;
      in_valid    = 1'b0;
      in_last     = 1'b0;
      coeff_ready = 1'b1;
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // UNIFORM len=3: 1, 0x7FFFFF rejected, 8380416; run left open
      push(32'd1, 9'd0);
      push(32'd8380416, 9'd1);
      begin_run(2'd0, 9'd3);
      send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
      send(8'hFF, 0); send(8'hFF, 0); send(8'hFF, 0);
      send(8'h00, 0); send(8'hE0, 0); send(8'h7F, 0);
      repeat (5) tick();
      check("uni_ctr", 64'(ctr), 64'd2);
      check("uni_not_done", {63'd0, done}, 64'd0);
      check("uni_busy", {63'd0, busy}, 64'd1);
      check("uni_sb", 64'(sb.size()), 64'd0);
      start = 1'b0;
      reset = 1'b1;
      tick();
      check_all_zero("abort");
      reset = 1'b0;
      tick();

      // ETA2 len=4: 0x3E -> -2,-1; 0xFF rejected twice; 0x50 -> 2,2
      push(32'hFFFF_FFFE, 9'd0);
      push(32'hFFFF_FFFF, 9'd1);
      push(32'd2, 9'd2);
      push(32'd2, 9'd3);
      begin_run(2'd1, 9'd4);
      send(8'h3E, 0); send(8'hFF, 0); send(8'h50, 0);
      wait_done();
      check("eta2_ctr", 64'(ctr), 64'd4);
      check("eta2_exh", {63'd0, exhausted}, 64'd0);
      check("eta2_busy", {63'd0, busy}, 64'd0);
      end_run();

      // ETA4 len=3 with the first coefficient held under backpressure
      push(32'd4, 9'd0);
      push(32'hFFFF_FFFC, 9'd1);
      push(32'hFFFF_FFFC, 9'd2);
      coeff_ready = 1'b0;
      begin_run(2'd2, 9'd3);
      send(8'h90, 0);
      for (int n = 0; n < 50 && !coeff_valid; n++) @(negedge clock);
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         check("bp_valid", {63'd0, coeff_valid}, 64'd1);
         check("bp_value", 64'(coeff_out), 64'd4);
         check("bp_idx", 64'(coeff_idx), 64'd0);
         check("bp_in_ready", {63'd0, in_ready}, 64'd0);
         check("bp_ctr", 64'(ctr), 64'd0);
      end
      tick();
      coeff_ready = 1'b1;
      send(8'h88, 0);
      wait_done();
      check("eta4_ctr", 64'(ctr), 64'd3);
      check("eta4_exh", {63'd0, exhausted}, 64'd0);
      end_run();

      // UNIFORM len=4, stream ends on a dangling 7th byte
      push(32'd1, 9'd0);
      push(32'd2, 9'd1);
      begin_run(2'd0, 9'd4);
      send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
      send(8'h02, 0); send(8'h00, 0); send(8'h00, 0);
      send(8'h03, 1);
      wait_done();
      check("exh_flag", {63'd0, exhausted}, 64'd1);
      check("exh_ctr", 64'(ctr), 64'd2);
      check("exh_in_ready", {63'd0, in_ready}, 64'd0);
      check("exh_busy", {63'd0, busy}, 64'd0);
      end_run();

      // Reset after one coefficient, then an empty run
      push(32'd1, 9'd0);
      begin_run(2'd0, 9'd5);
      send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
      for (int n = 0; n < 50 && ctr != 9'd1; n++) @(negedge clock);
      check("pre_reset_ctr", 64'(ctr), 64'd1);
      tick();
      start = 1'b0;
      reset = 1'b1;
      tick();
      check_all_zero("midrun");
      reset = 1'b0;
      begin_run(2'd1, 9'd0);
      tick();
      check("len0_done", {63'd0, done}, 64'd1);
      check("len0_ctr", 64'(ctr), 64'd0);
      check("len0_exh", {63'd0, exhausted}, 64'd0);
      check("len0_busy", {63'd0, busy}, 64'd0);
      end_run();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
